// File: rtl/bus_router.sv
// bus_router: routes one master bus cycle to one of 16 slave ports.
//
// The decoder's chipselect/fault are sampled when a request is seen in IDLE.
// A mapped request raises cyc/stb on the chosen slave until that slave acks.
// The cycle also ends if the master drops cyc_i or the watchdog expires.
// Decode faults and watchdog expiry are returned to the master as a one-cycle
// err_o pulse and are counted.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   cyc_i, stb_i        master cycle / strobe
//   chipselect, fault   decoder outputs for the current address
//   ack_o, err_o        registered one-cycle completion / bus error
//   dat_o               registered read data, valid with ack_o, held afterwards
//   s_cyc_o, s_stb_o    per-slave cyc / stb (bit n = slave n)
//   s_ack_i, s_dat_i    per-slave ack and read data (slave n on [32n+31:32n])
//   timeout_o           one-cycle pulse when the watchdog fires
//   err_count_o         saturating count of faults plus timeouts
module bus_router #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cyc_i,
    input  logic         stb_i,
    input  logic [3:0]   chipselect,
    input  logic         fault,
    output logic         ack_o,
    output logic         err_o,
    output logic [31:0]  dat_o,
    output logic [15:0]  s_cyc_o,
    output logic [15:0]  s_stb_o,
    input  logic [15:0]  s_ack_i,
    input  logic [511:0] s_dat_i,
    output logic         timeout_o,
    output logic [7:0]   err_count_o
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone, StErr} state_e;

    localparam logic [15:0] WdogLast = 16'(TIMEOUT - 1);

    state_e      state_q;
    logic [3:0]  cs_q;
    logic [15:0] wdog_q;
    logic        sel_ack;
    logic [31:0] sel_dat;

    assign sel_ack = s_ack_i[cs_q];
    assign sel_dat = s_dat_i[{cs_q, 5'd0} +: 32];

    // Strobes follow the master combinationally so an async reset or a
    // master abort removes them without waiting for a clock edge.
    always_comb begin
        s_cyc_o = '0;
        s_stb_o = '0;
        if (state_q == StBusy) begin
            s_cyc_o[cs_q] = cyc_i;
            s_stb_o[cs_q] = stb_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            cs_q        <= '0;
            wdog_q      <= '0;
            ack_o       <= 1'b0;
            err_o       <= 1'b0;
            timeout_o   <= 1'b0;
            dat_o       <= '0;
            err_count_o <= '0;
        end else begin
            ack_o     <= 1'b0;
            err_o     <= 1'b0;
            timeout_o <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (cyc_i && stb_i) begin
                        // Slave 0 doubles as "unmapped", so it is never routed.
                        if (fault || chipselect == 4'd0) begin
                            state_q <= StErr;
                            err_o   <= 1'b1;
                            if (err_count_o != 8'hFF) err_count_o <= err_count_o + 8'd1;
                        end else begin
                            cs_q    <= chipselect;
                            wdog_q  <= '0;
                            state_q <= StBusy;
                        end
                    end
                end
                StBusy: begin
                    // Ack wins over abort, abort wins over timeout.
                    if (sel_ack) begin
                        dat_o   <= sel_dat;
                        ack_o   <= 1'b1;
                        state_q <= StDone;
                    end else if (!cyc_i) begin
                        state_q <= StIdle;
                    end else if (wdog_q == WdogLast) begin
                        state_q   <= StErr;
                        err_o     <= 1'b1;
                        timeout_o <= 1'b1;
                        if (err_count_o != 8'hFF) err_count_o <= err_count_o + 8'd1;
                    end else begin
                        wdog_q <= wdog_q + 16'd1;
                    end
                end
                StDone:  state_q <= StIdle;
                StErr:   state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
